// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH itself, hence the +1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_shift_add_step.sv
// One radix-2 partial-product step: acc + (lsb ? mcand << count : 0).
module shift_add_step
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*WIDTH-1:0]        i_acc,
  input  logic [WIDTH-1:0]          i_mcand,
  input  logic                      i_mplier_lsb,
  input  logic [cnt_w(WIDTH)-1:0]   i_count,
  output logic [2*WIDTH-1:0]        o_acc
);

  logic [2*WIDTH-1:0] w_addend;

  always_comb begin
    w_addend = '0;
    if (i_mplier_lsb) begin
      w_addend = {{WIDTH{1'b0}}, i_mcand} << i_count;
    end
    o_acc = i_acc + w_addend;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier with optional signed mode and
// start/busy/done handshake; one partial product per clock.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_signed_op;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_count_last;
  logic [2*WIDTH-1:0]   w_next_acc;
  logic [2*WIDTH-1:0]   w_result;

  // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
  always_comb begin
    w_signed_op  = signed_mode & SIGNED_EN;
    w_a_mag      = (w_signed_op && a[WIDTH-1]) ? -a : a;
    w_b_mag      = (w_signed_op && b[WIDTH-1]) ? -b : b;
    w_count_last = (r_count == CNT_W'(WIDTH));
    w_result     = r_neg ? -r_acc : r_acc;
  end

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc        (r_acc),
    .i_mcand      (r_mcand),
    .i_mplier_lsb (r_mplier[0]),
    .i_count      (r_count),
    .o_acc        (w_next_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next_state = start ? ST_CALC : ST_IDLE;
      ST_CALC: w_next_state = w_count_last ? ST_DONE : ST_CALC;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_CALC) || (r_state == ST_DONE);
    done = (r_state == ST_DONE);
  end

  // The CALC cycle with count==WIDTH only resolves the sign, giving the WIDTH+2 cadence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        ST_CALC: begin
          if (!w_count_last) begin
            r_acc    <= w_next_acc;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
          end else begin
            r_product <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks of seq_multiplier at WIDTH=4 (signed enabled and disabled)
// plus a WIDTH=8 sweep against a behavioural product.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, sm4;
  logic [3:0] a4, b4;
  logic       busy0, done0, busy1, done1;
  logic [7:0] prod0, prod1;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy2, done2;
  logic [15:0] prod2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy0), .done(done0), .product(prod0));

  seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy1), .done(done1), .product(prod1));

  seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy2), .done(done2), .product(prod2));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // exp_s: SIGNED_EN=1 instance, exp_u: SIGNED_EN=0 instance.
  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic sm, input logic [7:0] exp_s, input logic [7:0] exp_u);
    int cyc;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b;
    cyc = 0;
    check_eq({tag, "_busy"}, 32'(busy0), 32'd1);
    while (!done0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'd5);
    check_eq({tag, "_prod_s"}, 32'(prod0), 32'(exp_s));
    check_eq({tag, "_prod_u"}, 32'(prod1), 32'(exp_u));
    @(negedge clk);
    check_eq({tag, "_idle"}, 32'({busy0, done0}), 32'd0);
    check_eq({tag, "_hold"}, 32'(prod0), 32'(exp_s));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int cyc;
    logic [15:0] exp;
    if (sm) exp = 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
    else    exp = {8'b0, a} * {8'b0, b};
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("w8_lat", 32'(cyc), 32'd9);
    check_eq("w8_prod", 32'(prod2), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    logic [7:0] seen;
    int cyc;

    rst_n = 1'b0; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy_done", 32'({busy0, done0, busy1, done1, busy2, done2}), 32'd0);
    check_eq("rst_prod4", 32'({prod0, prod1}), 32'd0);
    check_eq("rst_prod8", 32'(prod2), 32'd0);
    rst_n = 1'b1;

    run4("u_fxf",     4'hF, 4'hF, 1'b0, 8'hE1, 8'hE1);
    run4("s_m8x7",    4'h8, 4'h7, 1'b1, 8'hC8, 8'h38);
    run4("s_m8xm8",   4'h8, 4'h8, 1'b1, 8'h40, 8'h40);
    run4("s_m1x0",    4'hF, 4'h0, 1'b1, 8'h00, 8'h00);
    run4("u_0x9",     4'h0, 4'h9, 1'b0, 8'h00, 8'h00);
    run4("s_m1x2",    4'hF, 4'h2, 1'b1, 8'hFE, 8'h1E);
    run4("s_7x7",     4'h7, 4'h7, 1'b1, 8'h31, 8'h31);
    run4("s_5xm3",    4'h5, 4'hD, 1'b1, 8'hF1, 8'h41);

    // start held high with operands changing while busy
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0;
    @(negedge clk);
    ndone = 0; seen = '0;
    for (int c = 1; c <= 6; c++) begin
      a4 = 4'(a4 + 4'd1);
      b4 = b4 ^ 4'hA;
      @(negedge clk);
      if (done0) begin
        ndone++;
        seen = prod0;
      end
    end
    check_eq("hold_single_done", 32'(ndone), 32'd1);
    check_eq("hold_first_ops", 32'(seen), 32'h0F);
    check_eq("hold_back_idle", 32'(busy0), 32'd0);
    a4 = 4'd2; b4 = 4'd6;
    @(negedge clk);
    check_eq("hold_restart", 32'(busy0), 32'd1);
    start4 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("hold_second_prod", 32'(prod0), 32'h0C);
    @(negedge clk);

    // reset mid-CALC after two partial products
    @(negedge clk);
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; sm4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", 32'({busy0, busy1}), 32'd0);
    check_eq("midrst_done", 32'({done0, done1}), 32'd0);
    check_eq("midrst_prod", 32'({prod0, prod1}), 32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    check_eq("midrst_no_done", 32'(ndone), 32'd0);
    run4("after_rst_3x5", 4'h3, 4'h5, 1'b0, 8'h0F, 8'h0F);

    run8(8'h80, 8'h80, 1'b1);
    run8(8'h80, 8'h7F, 1'b1);
    run8(8'hFF, 8'hFF, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
